lc3_controller: RTL
===================

LC3_CONTROLLER -- requirements
Module: lc3_controller

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Ports (name, direction, width, meaning):
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- complete_instr  input  1  instruction fetch done; instr_dout valid
- instr_dout  input  16  fetched instruction word
- complete_data  input  1  current data-memory access done
- psr  input  3  NZP flags; valid during EXECUTE
- enable_fetch  output  1  fetch stage enable
- enable_decode  output  1  decode stage enable (drives the decode_in bus)
- enable_execute  output  1  execute stage enable
- enable_writeback  output  1  writeback stage enable
- enable_updatePC  output  1  PC update enable
- mem_state  output  2  0 READ, 1 WRITE, 2 INDIRECT, 3 IDLE
- br_taken  output  1  branch/jump decision for PC update

Function
REQ-003 SHALL implement a Moore FSM with states FETCH, DECODE, EXECUTE, MEM, WRITEBACK, UPDATE_PC.
REQ-004 Each enable_* output SHALL be high only in its namesake state; at most one enable SHALL be high per cycle.
REQ-005 FETCH SHALL hold until complete_instr=1, then capture instr_dout into IR and go to DECODE; complete_instr SHALL be ignored in other states.
REQ-006 DECODE SHALL last exactly 1 cycle, then go to EXECUTE.
REQ-007 EXECUTE SHALL last 1 cycle; the next state SHALL be chosen by IR[15:12]:
- ADD 0001, AND 0101, NOT 1001, LEA 1110 -> WRITEBACK
- LD 0010, LDR 0110, LDI 1010, ST 0011, STR 0111, STI 1011 -> MEM
- BR 0000, JMP 1100 -> UPDATE_PC
- any other opcode -> UPDATE_PC (NOP)
REQ-008 On leaving EXECUTE, br_taken SHALL be registered:
- BR: |(IR[11:9] & psr)
- JMP: 1
- otherwise: 0
- br_taken SHALL hold until the next EXECUTE.
REQ-009 MEM phase sequences SHALL be:
- LD/LDR: READ
- LDI: INDIRECT then READ
- ST/STR: WRITE
- STI: INDIRECT then WRITE
REQ-010 Each MEM phase SHALL hold mem_state until complete_data=1, then advance on the next edge.
REQ-011 After MEM, loads SHALL go to WRITEBACK and stores SHALL go to UPDATE_PC.
REQ-012 mem_state SHALL be IDLE (3) in every state other than MEM.
REQ-013 complete_data outside MEM SHALL be ignored.
REQ-014 WRITEBACK and UPDATE_PC SHALL each last 1 cycle; WRITEBACK goes to UPDATE_PC, and UPDATE_PC goes to FETCH.
REQ-015 Minimum latency SHALL be 5 cycles for ALU/LEA ops, 4 for BR/JMP, and 6 for LD when complete_data is high in its first MEM cycle.

Reset
REQ-016 While reset=1 at an edge:
- state SHALL become FETCH
- IR SHALL become 0, br_taken 0, mem_state IDLE
- all enables SHALL be 0 (gated while reset is high)
REQ-017 Reset asserted mid-operation (including MEM) SHALL abort the instruction without completing writeback or PC update.
REQ-018 enable_fetch SHALL be 1 in the first cycle with reset low.

Structure
REQ-019 Package lc3_ctrl_pkg SHALL hold the FSM state enum, the mem_state enum, and the opcode constants.
REQ-020 The combinational opcode classifier (ALU / load / store / indirect / branch / NOP) SHALL be sub-module lc3_ctrl_opclass.

Verification
REQ-021 ADD x1042, complete_instr on the first FETCH cycle -> enables F,D,E,W,U in 5 consecutive cycles; mem_state stays 3; br_taken 0.
REQ-022 LDI xA200, complete_data 2 cycles into each phase -> mem_state 2 for 2 cycles, then 0 for 2 cycles, then WRITEBACK, then UPDATE_PC.
REQ-023 BR x0402 (nzp=010):
- psr=100 -> br_taken 0 at UPDATE_PC
- repeat with psr=010 -> br_taken 1
- no WRITEBACK in either case
REQ-024 STR x7042 -> mem_state 1 until complete_data, then UPDATE_PC; enable_writeback never asserted.
REQ-025 Reset asserted during LDI INDIRECT -> next cycle all enables 0 and mem_state 3; after release, enable_fetch=1 immediately.
REQ-026 Opcode 1101, plus complete_data pulses during DECODE -> E then U, with no MEM entry.

Source files
------------

// File: rtl/lc3_ctrl_pkg.sv
// Shared types and constants for the LC-3 instruction sequencing controller.
// Contents: FSM state enum, memory-access phase enum, opcode constants.
package lc3_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_UPDATE_PC = 3'd5
  } state_e;

  // Encoding is visible on the mem_state output, so values are fixed.
  typedef enum logic [1:0] {
    MEM_READ     = 2'd0,
    MEM_WRITE    = 2'd1,
    MEM_INDIRECT = 2'd2,
    MEM_IDLE     = 2'd3
  } mem_state_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

endpackage

// File: rtl/lc3_ctrl_opclass.sv
// Combinational opcode classifier.
// Ports: opcode_i (IR[15:12]) in; one-hot-ish class flags out. is_indirect_o
// is set alongside is_load_o/is_store_o for LDI/STI. Unlisted opcodes -> NOP.
module lc3_ctrl_opclass
  import lc3_ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       is_alu_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_indirect_o,
  output logic       is_br_o,
  output logic       is_jmp_o,
  output logic       is_nop_o
);

  always_comb begin
    is_alu_o      = 1'b0;
    is_load_o     = 1'b0;
    is_store_o    = 1'b0;
    is_indirect_o = 1'b0;
    is_br_o       = 1'b0;
    is_jmp_o      = 1'b0;
    is_nop_o      = 1'b0;
    case (opcode_i)
      OP_ADD, OP_AND, OP_NOT, OP_LEA: is_alu_o = 1'b1;
      OP_LD, OP_LDR:                  is_load_o = 1'b1;
      OP_LDI: begin
        is_load_o     = 1'b1;
        is_indirect_o = 1'b1;
      end
      OP_ST, OP_STR:                  is_store_o = 1'b1;
      OP_STI: begin
        is_store_o    = 1'b1;
        is_indirect_o = 1'b1;
      end
      OP_BR:                          is_br_o = 1'b1;
      OP_JMP:                         is_jmp_o = 1'b1;
      default:                        is_nop_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/lc3_controller.sv
// LC-3 multi-cycle control FSM (Moore). Sequences fetch, decode, execute,
// memory, writeback and PC update, one stage enable at a time.
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   complete_instr       fetch done; instr_dout captured into IR in FETCH
//   instr_dout[15:0]     fetched instruction word
//   complete_data        current memory phase done (only looked at in MEM)
//   psr[2:0]             NZP flags, sampled when leaving EXECUTE
//   enable_*             stage enables, high only in the namesake state
//   mem_state[1:0]       0 READ, 1 WRITE, 2 INDIRECT, 3 IDLE
//   br_taken             registered branch/jump decision, held until next EXECUTE
//
// state       | meaning
// FETCH       | wait for complete_instr, capture IR
// DECODE      | one cycle, decode bus driven
// EXECUTE     | one cycle, opcode picks next state, br_taken registered
// MEM         | one or two phases (INDIRECT first for LDI/STI), each waits complete_data
// WRITEBACK   | one cycle, loads and ALU/LEA only
// UPDATE_PC   | one cycle, back to FETCH
module lc3_controller
  import lc3_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic [15:0] instr_dout,
  input  logic        complete_data,
  input  logic [2:0]  psr,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        enable_updatePC,
  output logic [1:0]  mem_state,
  output logic        br_taken
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        br_taken_q, br_taken_d;
  // Set once the INDIRECT phase of LDI/STI has completed.
  logic        ind_done_q, ind_done_d;

  logic is_alu, is_load, is_store, is_indirect, is_br, is_jmp, is_nop;

  lc3_ctrl_opclass u_opclass (
    .opcode_i      (ir_q[15:12]),
    .is_alu_o      (is_alu),
    .is_load_o     (is_load),
    .is_store_o    (is_store),
    .is_indirect_o (is_indirect),
    .is_br_o       (is_br),
    .is_jmp_o      (is_jmp),
    .is_nop_o      (is_nop)
  );

  // Operand fields of IR are consumed by the datapath, not here.
  logic unused_ir;
  assign unused_ir = ^ir_q[8:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      br_taken_q <= 1'b0;
      ind_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      br_taken_q <= br_taken_d;
      ind_done_q <= ind_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    br_taken_d = br_taken_q;
    ind_done_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (complete_instr) begin
          ir_d    = instr_dout;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        br_taken_d = is_jmp | (is_br & |(ir_q[11:9] & psr));
        if (is_alu)
          state_d = S_WRITEBACK;
        else if (is_load || is_store)
          state_d = S_MEM;
        else if (is_br || is_jmp || is_nop)
          state_d = S_UPDATE_PC;
      end
      S_MEM: begin
        ind_done_d = ind_done_q;
        if (complete_data) begin
          if (is_indirect && !ind_done_q)
            ind_done_d = 1'b1;
          else
            state_d = is_load ? S_WRITEBACK : S_UPDATE_PC;
        end
      end
      S_WRITEBACK: state_d = S_UPDATE_PC;
      S_UPDATE_PC: state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // Outputs are forced quiet combinationally while reset is high so an
  // aborted instruction cannot strobe writeback or PC update.
  always_comb begin
    enable_fetch     = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    enable_updatePC  = 1'b0;
    mem_state        = MEM_IDLE;
    if (!reset) begin
      case (state_q)
        S_FETCH:     enable_fetch     = 1'b1;
        S_DECODE:    enable_decode    = 1'b1;
        S_EXECUTE:   enable_execute   = 1'b1;
        S_WRITEBACK: enable_writeback = 1'b1;
        S_UPDATE_PC: enable_updatePC  = 1'b1;
        S_MEM: begin
          if (is_indirect && !ind_done_q)
            mem_state = MEM_INDIRECT;
          else if (is_load)
            mem_state = MEM_READ;
          else
            mem_state = MEM_WRITE;
        end
        default: ;
      endcase
    end
  end

  assign br_taken = br_taken_q;

endmodule
